// File: rtl/f2m_sqr_seq.sv
// Repeated squaring over F_2^m: z = a^(2^k) mod f(x), one squaring per clock.
// f2m_sqr is the combinational squarer; f2m_sqr_seq sequences it over an accumulator.

module f2m_sqr #(
    parameter int          M  = 163,
    parameter logic [M-1:0] FX = 163'hc9
) (
    input  logic [M-1:0] i_a,
    output logic [M-1:0] o_z
);

    // Squaring in GF(2) spreads bits to even positions; high terms fold back via x^M = FX.
    function automatic logic [M-1:0] sqr_mod(input logic [M-1:0] a_in);
        logic [2*M-2:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            r[2*i] = a_in[i];
        end
        for (int i = 2*M-2; i >= M; i--) begin
            if (r[i]) begin
                r[i-M +: M] = r[i-M +: M] ^ FX;
                r[i]        = 1'b0;
            end
        end
        return r[M-1:0];
    endfunction

    assign o_z = sqr_mod(i_a);

endmodule

module f2m_sqr_seq #(
    parameter int          M  = 163,
    parameter logic [M-1:0] FX = 163'hc9,
    parameter int          KW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [M-1:0]  a,
    input  logic [KW-1:0] k,
    output logic          busy,
    output logic          done,
    output logic [M-1:0]  z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [M-1:0]  r_acc;
    logic [KW-1:0] r_cnt;
    logic [M-1:0]  r_z;
    logic          r_busy;
    logic          r_done;
    logic [M-1:0]  w_sqr;
    logic          w_accept;
    logic          w_k_zero;
    logic          w_last;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    f2m_sqr #(.M(M), .FX(FX)) u_sqr (
        .i_a (r_acc),
        .o_z (w_sqr)
    );

    // DONE accepts a new request so back-to-back operations lose no cycle.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_k_zero = (k == {KW{1'b0}});
    assign w_last   = (r_cnt == {{(KW-1){1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_k_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so busy/done are flop outputs.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN:   w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Datapath: accumulator, squaring counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {M{1'b0}};
            r_cnt <= {KW{1'b0}};
            r_z   <= {M{1'b0}};
        end else if (w_accept) begin
            r_acc <= a;
            r_cnt <= k;
            if (w_k_zero) begin
                r_z <= a;
            end
        end else if (r_state == S_RUN) begin
            r_acc <= w_sqr;
            r_cnt <= r_cnt - {{(KW-1){1'b0}}, 1'b1};
            if (w_last) begin
                r_z <= w_sqr;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign z    = r_z;

endmodule

// File: tb/tb_f2m_sqr_seq.sv
// Self-checking bench for f2m_sqr_seq: directed test-plan vectors plus random
// operands checked against a shift-and-add GF(2^163) multiply model.

module tb_f2m_sqr_seq;

    localparam int          M  = 163;
    localparam int          KW = 8;
    localparam logic [M-1:0] FX = 163'hc9;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [M-1:0]  a;
    logic [KW-1:0] k;
    logic          busy;
    logic          done;
    logic [M-1:0]  z;

    int n_checks;
    int n_errors;

    f2m_sqr_seq #(.M(M), .FX(FX), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .k     (k),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] acc;
        logic [M-1:0] b;
        logic         carry;
        acc = '0;
        b   = x;
        for (int i = 0; i < M; i++) begin
            if (y[i]) acc = acc ^ b;
            carry = b[M-1];
            b     = b << 1;
            if (carry) b = b ^ FX;
        end
        return acc;
    endfunction

    function automatic logic [M-1:0] ref_pow2k(input logic [M-1:0] x, input int kk);
        logic [M-1:0] r;
        r = x;
        for (int i = 0; i < kk; i++) r = gf_mul(r, r);
        return r;
    endfunction

    function automatic logic [M-1:0] rand_poly();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[M-1:0];
    endfunction

    task automatic run_op(input logic [M-1:0] ia, input int ik, input logic [M-1:0] exp_z, input string name);
        logic [M-1:0] zprev;
        int cyc;
        zprev = z;
        a = ia;
        k = ik[KW-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = rand_poly();
        k = KW'($urandom_range(0, 255));
        cyc = 1;
        while (done !== 1'b1 && cyc < 400) begin
            n_checks++;
            if (busy !== 1'b1 || z !== zprev) begin
                n_errors++;
                $display("FAIL %s_running cyc %0d: busy %b z %h, expected busy 1 z %h", name, cyc, busy, z, zprev);
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== ik + 1) begin
            n_errors++;
            $display("FAIL %s_latency: done in cycle %0d, expected %0d", name, cyc, ik + 1);
        end
        n_checks++;
        if (z !== exp_z) begin
            n_errors++;
            $display("FAIL %s_z: got %h expected %h", name, z, exp_z);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_busy_at_done: got %b expected 0", name, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || z !== exp_z) begin
            n_errors++;
            $display("FAIL %s_after_done: done %b z %h, expected done 0 z %h", name, done, z, exp_z);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        k = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || z !== '0) begin
            n_errors++;
            $display("FAIL reset_state: busy %b done %b z %h, expected 0 0 0", busy, done, z);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [M-1:0] v;
        run_op(163'h2, 1, 163'h4, "x_k1");
        v = 163'h1 << 82;
        run_op(v, 1, 163'h192, "x82_reduce");
        v = 163'h1 << 81;
        run_op(v, 1, 163'h1 << 162, "x81_top");
        run_op(163'h1, 5, 163'h1, "one_k5");
    endtask

    task automatic test_k_zero();
        run_op(163'h5a5a, 0, 163'h5a5a, "k0");
    endtask

    task automatic test_random();
        logic [M-1:0] ra;
        int rk;
        for (int t = 0; t < 6; t++) begin
            ra = rand_poly();
            rk = $urandom_range(1, 20);
            run_op(ra, rk, ref_pow2k(ra, rk), "random");
        end
    endtask

    task automatic test_fermat_ignore_b2b();
        logic [M-1:0] a1;
        logic [M-1:0] a2;
        logic [M-1:0] exp2;
        int k2;
        int cyc;
        bit got1;
        bit got2;
        a1 = rand_poly() | 163'h1;
        a2 = rand_poly();
        k2 = $urandom_range(1, 9);
        exp2 = ref_pow2k(a2, k2);
        got1 = 1'b0;
        got2 = 1'b0;
        a = a1;
        k = 8'd163;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 400 && !got2) begin
            start = 1'b0;
            if (done === 1'b1) begin
                if (!got1) begin
                    got1 = 1'b1;
                    n_checks++;
                    if (cyc !== 164) begin
                        n_errors++;
                        $display("FAIL fermat_latency: done in cycle %0d, expected 164", cyc);
                    end
                    n_checks++;
                    if (z !== a1) begin
                        n_errors++;
                        $display("FAIL fermat_z: got %h expected %h", z, a1);
                    end
                    a = a2;
                    k = k2[KW-1:0];
                    start = 1'b1;
                end else begin
                    got2 = 1'b1;
                    n_checks++;
                    if (cyc !== 164 + k2 + 1) begin
                        n_errors++;
                        $display("FAIL b2b_latency: done in cycle %0d, expected %0d", cyc, 164 + k2 + 1);
                    end
                    n_checks++;
                    if (z !== exp2) begin
                        n_errors++;
                        $display("FAIL b2b_z: got %h expected %h", z, exp2);
                    end
                end
            end else if (cyc >= 50 && cyc <= 60) begin
                a = rand_poly();
                k = KW'($urandom_range(1, 5));
                start = 1'b1;
            end
            if (!got2) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!(got1 && got2)) begin
            n_errors++;
            $display("FAIL fermat_timeout: got1 %b got2 %b, expected both 1", got1, got2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int pulses;
        a = 163'h2;
        k = 8'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || z !== '0) begin
            n_errors++;
            $display("FAIL midrun_reset: busy %b done %b z %h, expected 0 0 0", busy, done, z);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            if (done !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL midrun_no_done: got %0d done pulses, expected 0", pulses);
        end
        run_op(163'h2, 2, 163'h10, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_k_zero();
        test_random();
        test_fermat_ignore_b2b();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/f2m_sqr_seq.md
Name:
f2m_sqr_seq

Overview:
- Sequential multi-squaring controller over F_{2^m}: computes z = a^(2^k) mod f(x) by applying one combinational squaring per clock to an internal accumulator.
- Instantiates f2m_sqr with the same M/FX; feeds it from the accumulator and writes its output back.
- Used by the inversion (Itoh-Tsujii) and point-arithmetic sequencers for the repeated-squaring chains a^(2^k).
- Single-request start/done handshake.

Parameters:
- M, 163, degree of f(x).
- FX, 163'hc9, binary representation of f(x) without the x^M term; passed to f2m_sqr.
- KW, 8, width of the squaring-count input k. Must satisfy 2^KW-1 >= M so that k = M is expressible.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy = 0.
- a  input  M  operand polynomial; captured on an accepted start.
- k  input  KW  number of squarings; captured on an accepted start.
- busy  output  1  high while squaring is in progress.
- done  output  1  one-cycle pulse when z is updated with a new result.
- z  output  M  result a^(2^k) mod f(x); registered; held until the next done.

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n); all flops are cleared immediately when rst_n = 0.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, z = 0
  - accumulator = 0, counter = 0
- States: IDLE, RUN, DONE.
- Accepted start: start = 1 while state is IDLE or DONE. DONE accepts start so that requests can run back-to-back.
  - The accumulator loads a and the counter loads k.
  - If k = 0: next state is DONE and z <= a.
  - If k != 0: next state is RUN.
- RUN, on each clock edge:
  - accumulator <= sqr(accumulator); counter <= counter - 1.
  - When counter = 1 before the edge: next state is DONE and z <= sqr(accumulator).
- DONE:
  - done = 1 for exactly this one cycle.
  - Next state is IDLE, or RUN/DONE if a new start is accepted in this same cycle.
- busy = 1 exactly when state = RUN. It is a registered state decode and has no combinational path from start.
- Start while busy = 1 is ignored. a and k are not sampled, and the operation in progress is not disturbed.
- Latency: with the start cycle numbered 0, done is high in cycle k+1 for every k in 0 .. 2^KW-1. Throughput is one result per k+1 cycles when requests are back-to-back.
- z changes only on the edge that enters DONE. Intermediate accumulator values are never visible on z.
- a and k may change freely after the accepted start cycle.
- k = 0 is legal and returns a unreduced. The a input must already be reduced (degree < M).
- Reset asserted mid-RUN aborts the operation with no done pulse and clears z to 0. The first start after reset release behaves normally.
- The squaring is combinational from accumulator to accumulator (one f2m_sqr instance); no other pipelining.

Test Plan:
- Reset, then a = 163'h2 (x), k = 1, start in cycle 0:
  - busy is high in cycle 1; done is high in cycle 2.
  - z = 163'h4.
- a = 1 << 82 (x^82), k = 1 -> z = x^164 mod f = 163'h192, done in cycle 2. This exercises reduction.
- a = 1 << 81, k = 1 -> z = 1 << 162. a = 163'h1, k = 5 -> z = 163'h1, done in cycle 6.
- k = 0, a = 163'h5a5a -> done in cycle 1, z = 163'h5a5a, busy never asserted.
- k = 163 with a random nonzero a -> z = a (Fermat), done in cycle 164.
  - A second start with different a/k issued in cycles 50..60 is ignored.
  - A start asserted in the DONE cycle is accepted, and its result is correct.
- Start with k = 10, then drop rst_n in cycle 4:
  - busy, done and z are 0 immediately, and done never pulses.
  - After release, a = x with k = 2 gives z = 163'h10 in cycle 3.
